bist_session_ctrl: RTL

BIST session controller for the TRC/CUT/MISR test structure. It drives the scan-enable (SE) of the pattern generator and MISR for a fixed number of test cycles per session. It then serially unloads the MISR signature, compares it against a per-session golden value, and reports an overall pass/fail once all sessions finish. It sits between the system/tester start request and the `TRCUTwithMISR` datapath, replacing hand-sequenced SE stimulus.

---
 rtl/bist_pkg.sv | 37 +++
 rtl/bist_sig_capture.sv | 30 +++
 rtl/bist_session_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST session controller.
// Optional build macro used by the top: BIST_STOP_ON_FAIL_EN.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_UNLOAD = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } bist_state_e;

  localparam int DEF_PAT_LEN  = 14;
  localparam int DEF_SIG_W    = 8;
  localparam int DEF_SESSIONS = 4;

  // Upper bounds for the generic slice helper below.
  localparam int MAX_SIG_W    = 64;
  localparam int MAX_GOLDEN_W = 1024;

  // Returns golden bits [idx*sig_w +: sig_w]; out-of-range indices give zero.
  function automatic logic [MAX_SIG_W-1:0] golden_slice(
    input logic [MAX_GOLDEN_W-1:0] golden,
    input int                      idx,
    input int                      sig_w
  );
    logic [MAX_GOLDEN_W-1:0] sh;
    logic [MAX_SIG_W-1:0]    res;
    sh  = golden >> (idx * sig_w);
    res = '0;
    for (int i = 0; i < MAX_SIG_W; i++) begin
      if (i < sig_w) res[i] = sh[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/bist_sig_capture.sv
// Serial-in signature capture: SIGN enters at the MSB and shifts right, so
// the first bit received lands in bit 0 after SIG_W shifts (SIG_W >= 2).
module bist_sig_capture
  import bist_pkg::*;
#(
  parameter int SIG_W = DEF_SIG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             sin,
  input  logic [SIG_W-1:0] golden,
  output logic [SIG_W-1:0] sig,
  output logic             match
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (shift_en) begin
      sig <= {sin, sig[SIG_W-1:1]};
    end
  end

  assign match = (sig == golden);

endmodule

// File: rtl/bist_session_ctrl.sv
// BIST session controller: runs SESSIONS x (RUN, UNLOAD, CHECK) and reports PASS/FAIL_IDX.
// Build macro: BIST_STOP_ON_FAIL_EN ends the run at the first mismatching session.
module bist_session_ctrl
  import bist_pkg::*;
#(
  parameter int                          PAT_LEN  = DEF_PAT_LEN,
  parameter int                          SIG_W    = DEF_SIG_W,
  parameter int                          SESSIONS = DEF_SESSIONS,
  parameter logic [SESSIONS*SIG_W-1:0]   GOLDEN   = '0
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic                          START,
  input  logic                          SIGN,
  output logic                          SE,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          PASS,
  output logic [$clog2(SESSIONS+1)-1:0] FAIL_IDX,
  output bist_state_e                   dbg_state
);

  localparam int CNT_MAX = (PAT_LEN > SIG_W) ? PAT_LEN : SIG_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SESS_W  = $clog2(SESSIONS + 1);

  // START is a level request, not a valid/ready handshake: it is sampled only
  // in S_IDLE and S_DONE and has no acknowledge; BUSY=1 means it is ignored.

  bist_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SESS_W-1:0] session_q, session_d, session_inc;
  logic [SESS_W-1:0] fail_q, fail_d;
  logic              pass_q, pass_d;
  logic              se_q, busy_q, done_q;
  logic              cap_clr, cap_shift, cap_match;
  logic [SIG_W-1:0]  cap_sig, golden_cur;

  assign golden_cur  = SIG_W'(golden_slice(MAX_GOLDEN_W'(GOLDEN), 32'(session_q), SIG_W));
  assign session_inc = session_q + SESS_W'(1);

  bist_sig_capture #(.SIG_W(SIG_W)) u_cap (
    .clk      (CLK),
    .rst_n    (RSTn),
    .clr      (cap_clr),
    .shift_en (cap_shift),
    .sin      (SIGN),
    .golden   (golden_cur),
    .sig      (cap_sig),
    .match    (cap_match)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    session_d = session_q;
    fail_d    = fail_q;
    pass_d    = pass_q;
    cap_clr   = 1'b0;
    cap_shift = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        cnt_d = cnt_q;
        if (START) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          session_d = '0;
          pass_d    = 1'b1;
          fail_d    = SESS_W'(SESSIONS);
          cap_clr   = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(PAT_LEN - 1)) begin
          state_d = S_UNLOAD;
          cnt_d   = '0;
        end
      end
      S_UNLOAD: begin
        cap_shift = 1'b1;
        if (cnt_q == CNT_W'(SIG_W - 1)) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end
      end
      S_CHECK: begin
        cnt_d     = '0;
        session_d = session_inc;
        state_d   = (session_inc == SESS_W'(SESSIONS)) ? S_DONE : S_RUN;
        if (!cap_match) begin
          pass_d = 1'b0;
          // Only the first failing session index is kept.
          if (fail_q == SESS_W'(SESSIONS)) fail_d = session_q;
`ifdef BIST_STOP_ON_FAIL_EN
          state_d = S_DONE;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      session_q <= '0;
      fail_q    <= SESS_W'(SESSIONS);
      pass_q    <= 1'b0;
      se_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      session_q <= session_d;
      fail_q    <= fail_d;
      pass_q    <= pass_d;
      // Outputs are registered from the next state so they align with it.
      se_q      <= (state_d == S_RUN);
      busy_q    <= (state_d == S_RUN) || (state_d == S_UNLOAD) || (state_d == S_CHECK);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign SE        = se_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q & done_q;
  assign FAIL_IDX  = fail_q;
  assign dbg_state = state_q;

endmodule
